// File: rtl/pm_pkg.sv
// Shared types and constants for the program-memory responder.
// Holds the boot FSM states, the fetch NOP and the loader halfword order.
package pm_pkg;

  typedef enum logic [1:0] {
    B_CNT = 2'd0,
    B_HI  = 2'd1,
    B_LO  = 2'd2,
    RUN   = 2'd3
  } pm_state_t;

  localparam logic [31:0] PM_NOP = 32'h0000_0000;

  // The loader streams the high halfword of each instruction first.
  localparam bit LDR_HI_FIRST = 1'b1;

  function automatic logic [31:0] pack_halves(input logic [15:0] first, input logic [15:0] second);
    return LDR_HI_FIRST ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/pm_ram.sv
// Single-port DEPTH x 32 instruction store with registered read data.
// Read data only updates on a read, so it holds across idle and write cycles.
module pm_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_fetch,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_fetch) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pm_resp.sv
// Program-memory responder: boots the PM RAM from a 16-bit loader stream,
// stalls the sequencer until loading completes, then serves fetches.
module pm_resp
  import pm_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk_fetch,
  input  logic        rst,
  input  logic        ps_pm_cslt,
  input  logic        ps_pm_wrb,
  input  logic [15:0] ps_pm_add,
  input  logic [31:0] ps_pm_wdt,
  output logic [31:0] pm_ps_op,
  input  logic        ldr_vld,
  input  logic [15:0] ldr_dt,
  output logic        ldr_rdy,
  output logic        pm_stallb,
  output logic        boot_done,
  output logic        pm_oob
);

  pm_state_t     state_reg, state_next;
  logic [AW:0]   n_reg, n_next, n_clamped;
  logic [AW-1:0] lp_reg, lp_next;
  logic [15:0]   hi_reg, hi_next;
  logic          ldr_rdy_reg, oob_reg, op_zero_reg;

  logic          hs, in_run, fetch, addr_oob;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  assign hs       = ldr_vld & ldr_rdy_reg;
  assign in_run   = (state_reg == RUN);
  assign fetch    = in_run & ps_pm_cslt;
  assign addr_oob = |ps_pm_add[15:AW];

  always_comb begin
    n_clamped  = ldr_dt[AW:0];
    state_next = state_reg;
    n_next     = n_reg;
    lp_next    = lp_reg;
    hi_next    = hi_reg;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = lp_reg;
    ram_wdata  = pack_halves(hi_reg, ldr_dt);

    // Counts beyond the store size are clamped; the surplus is never accepted.
    if (ldr_dt > 16'(DEPTH)) n_clamped = (AW+1)'(DEPTH);

    case (state_reg)
      B_CNT: if (hs) begin
        n_next     = n_clamped;
        lp_next    = '0;
        state_next = (n_clamped == '0) ? RUN : B_HI;
      end
      B_HI: if (hs) begin
        hi_next    = ldr_dt;
        state_next = B_LO;
      end
      B_LO: if (hs) begin
        ram_we = 1'b1;
        if ({1'b0, lp_reg} == n_reg - (AW+1)'(1)) begin
          state_next = RUN;
        end else begin
          lp_next    = lp_reg + AW'(1);
          state_next = B_HI;
        end
      end
      RUN: if (fetch && !addr_oob) begin
        ram_addr  = ps_pm_add[AW-1:0];
        ram_wdata = ps_pm_wdt;
        ram_we    = ~ps_pm_wrb;
        ram_re    = ps_pm_wrb;
      end
      default: state_next = B_CNT;
    endcase
  end

  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      state_reg   <= B_CNT;
      n_reg       <= '0;
      lp_reg      <= '0;
      hi_reg      <= '0;
      ldr_rdy_reg <= 1'b0;
      oob_reg     <= 1'b0;
      op_zero_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      n_reg       <= n_next;
      lp_reg      <= lp_next;
      hi_reg      <= hi_next;
      ldr_rdy_reg <= (state_next != RUN);
      oob_reg     <= oob_reg | (fetch & addr_oob);
      // Only an in-range read exposes RAM data; boot, writes and OOB give NOP.
      if (!in_run)    op_zero_reg <= 1'b1;
      else if (fetch) op_zero_reg <= ~(ps_pm_wrb & ~addr_oob);
    end
  end

  pm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_fetch (clk_fetch),
    .we        (ram_we),
    .re        (ram_re),
    .addr      (ram_addr),
    .wdata     (ram_wdata),
    .rdata     (ram_rdata)
  );

  assign pm_ps_op  = op_zero_reg ? PM_NOP : ram_rdata;
  assign ldr_rdy   = ldr_rdy_reg;
  assign pm_stallb = in_run;
  assign boot_done = in_run;
  assign pm_oob    = oob_reg;

endmodule

// File: tb/tb_pm_resp.sv
// Randomized bench for pm_resp against a halfword-counting reference model.
module tb_pm_resp;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_fetch = 1'b0;
  logic        rst = 1'b1;
  logic        ps_pm_cslt = 1'b0;
  logic        ps_pm_wrb = 1'b1;
  logic [15:0] ps_pm_add = '0;
  logic [31:0] ps_pm_wdt = '0;
  logic [31:0] pm_ps_op;
  logic        ldr_vld = 1'b0;
  logic [15:0] ldr_dt = '0;
  logic        ldr_rdy, pm_stallb, boot_done, pm_oob;

  always #5 clk_fetch = ~clk_fetch;

  pm_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_fetch (clk_fetch),
    .rst       (rst),
    .ps_pm_cslt(ps_pm_cslt),
    .ps_pm_wrb (ps_pm_wrb),
    .ps_pm_add (ps_pm_add),
    .ps_pm_wdt (ps_pm_wdt),
    .pm_ps_op  (pm_ps_op),
    .ldr_vld   (ldr_vld),
    .ldr_dt    (ldr_dt),
    .ldr_rdy   (ldr_rdy),
    .pm_stallb (pm_stallb),
    .boot_done (boot_done),
    .pm_oob    (pm_oob)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: boot is a count of accepted halfwords, memory an array.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_run, m_rdy, m_wait_n, m_oob, m_op_known;
  logic [31:0] m_op;
  logic [15:0] m_hi;
  int          m_n, m_h;
  bit          last_hs;
  logic [15:0] sq [$];

  task automatic model_reset();
    m_run = 0; m_rdy = 0; m_wait_n = 1; m_oob = 0;
    m_op = 32'h0; m_op_known = 1; m_n = 0; m_h = 0; m_hi = '0;
  endtask

  task automatic check_all(input string tag);
    if (m_op_known) chk({tag, ".op"}, pm_ps_op, m_op);
    chk({tag, ".rdy"},    32'(ldr_rdy),   32'(m_rdy));
    chk({tag, ".stallb"}, 32'(pm_stallb), 32'(m_run));
    chk({tag, ".done"},   32'(boot_done), 32'(m_run));
    chk({tag, ".oob"},    32'(pm_oob),    32'(m_oob));
  endtask

  task automatic tick(input string tag);
    int a;
    bit hs, fet;
    hs  = ldr_vld && m_rdy;
    fet = m_run && ps_pm_cslt;
    a   = int'(ps_pm_add);
    if (fet) begin
      if (a >= DEPTH) begin
        m_op = 32'h0; m_op_known = 1; m_oob = 1;
      end else if (ps_pm_wrb) begin
        m_op = m_mem[a]; m_op_known = m_known[a];
      end else begin
        m_mem[a] = ps_pm_wdt; m_known[a] = 1; m_op = 32'h0; m_op_known = 1;
      end
    end
    if (!m_run && hs) begin
      if (m_wait_n) begin
        m_n = (int'(ldr_dt) > DEPTH) ? DEPTH : int'(ldr_dt);
        m_wait_n = 0; m_h = 0;
        if (m_n == 0) m_run = 1;
      end else begin
        if (m_h % 2 == 0) m_hi = ldr_dt;
        else begin
          m_mem[m_h/2] = {m_hi, ldr_dt}; m_known[m_h/2] = 1;
        end
        m_h++;
        if (m_h == 2*m_n) m_run = 1;
      end
    end
    m_rdy = !m_run;
    last_hs = hs;
    @(posedge clk_fetch); #1;
    if (hs || fet)
      $display("t=%0t %s hs=%0b dt=%h cs=%0b wrb=%0b add=%h op=%h oob=%0b",
               $time, tag, hs, ldr_dt, fet, ps_pm_wrb, ps_pm_add, pm_ps_op, pm_oob);
    check_all(tag);
  endtask

  task automatic do_reset();
    ldr_vld = 0; ps_pm_cslt = 0;
    rst = 1'b0;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clk_fetch); #1;
    check_all("rst_hold");
    #2 rst = 1'b1;
  endtask

  task automatic send(input int max_hs, input int gap_pct, output int n_hs);
    int idx = 0;
    int cyc = 0;
    n_hs = 0;
    while (idx < sq.size() && n_hs < max_hs && !m_run && cyc < 2000) begin
      ldr_vld = ($urandom_range(99) >= gap_pct);
      ldr_dt  = ldr_vld ? sq[idx] : 16'($urandom);
      tick("boot");
      if (last_hs) begin idx++; n_hs++; end
      cyc++;
    end
    ldr_vld = 0;
    if (cyc >= 2000) chk("boot_timeout", 32'(cyc), 32'(0));
  endtask

  task automatic fetch(input bit wr, input logic [15:0] a, input logic [31:0] d, input string tag);
    ps_pm_cslt = 1; ps_pm_wrb = !wr; ps_pm_add = a; ps_pm_wdt = d;
    tick(tag);
    ps_pm_cslt = 0;
  endtask

  task automatic rand_run(input int cycles, input int oob_pct);
    for (int i = 0; i < cycles; i++) begin
      ps_pm_cslt = ($urandom_range(3) != 0);
      ps_pm_wrb  = ($urandom_range(2) != 0);
      ps_pm_add  = ($urandom_range(99) < oob_pct) ? 16'($urandom) : 16'($urandom_range(DEPTH-1));
      ps_pm_wdt  = $urandom;
      ldr_vld    = $urandom_range(1);
      ldr_dt     = 16'($urandom);
      tick("run");
    end
    ps_pm_cslt = 0; ldr_vld = 0;
  endtask

  initial begin
    int nh;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    #1;
    do_reset();

    // Reference boot with random loader gaps.
    sq = '{16'd3, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0000, 16'h0001};
    send(100, 30, nh);
    chk("boot_hs", 32'(nh), 32'(7));
    chk("boot_done_up", 32'(boot_done), 32'(1));
    fetch(0, 16'd0, 32'h0, "rd0"); chk("rd0_val", pm_ps_op, 32'h12345678);
    fetch(0, 16'd1, 32'h0, "rd1"); chk("rd1_val", pm_ps_op, 32'h9ABCDEF0);
    fetch(0, 16'd2, 32'h0, "rd2"); chk("rd2_val", pm_ps_op, 32'h00000001);

    fetch(1, 16'd5, 32'hCAFEF00D, "wr5"); chk("wr5_op", pm_ps_op, 32'h0);
    fetch(0, 16'd5, 32'h0, "rd5");        chk("rd5_val", pm_ps_op, 32'hCAFEF00D);
    tick("idle");                         chk("idle_hold", pm_ps_op, 32'hCAFEF00D);

    // Out-of-range accesses: read 0x0100, write at the first address past the store.
    fetch(0, 16'h0100, 32'h0, "oob_rd"); chk("oob_rd_op", pm_ps_op, 32'h0);
    chk("oob_set", 32'(pm_oob), 32'(1));
    fetch(1, 16'h0010, 32'hDEADBEEF, "oob_wr");
    fetch(0, 16'd0, 32'h0, "rd0b"); chk("oob_wr_drop", pm_ps_op, 32'h12345678);
    chk("oob_sticky", 32'(pm_oob), 32'(1));
    rand_run(200, 10);

    // Zero count: straight to RUN, loader stays ignored.
    do_reset();
    sq = '{16'd0};
    send(100, 20, nh);
    chk("zero_hs", 32'(nh), 32'(1));
    ldr_vld = 1;
    for (int i = 0; i < 4; i++) tick("zero_ign");
    ldr_vld = 0;

    // Clamp: N=20 against a 16-word store.
    do_reset();
    sq = '{16'd20};
    for (int i = 0; i < 2*DEPTH + 6; i++) sq.push_back(16'($urandom));
    send(200, 20, nh);
    chk("clamp_hs", 32'(nh), 32'(2*DEPTH + 1));
    ldr_vld = 1;
    for (int i = 0; i < 5; i++) tick("clamp_ign");
    ldr_vld = 0;
    for (int i = 0; i < DEPTH; i++) fetch(0, 16'(i), 32'h0, "clamp_rd");

    // Reset after four handshakes, then a one-word load.
    do_reset();
    sq = '{16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    send(4, 0, nh);
    chk("mid_hs", 32'(nh), 32'(4));
    do_reset();
    sq = '{16'd1, 16'hAAAA, 16'h5555};
    send(100, 25, nh);
    chk("reload_hs", 32'(nh), 32'(3));
    fetch(0, 16'd0, 32'h0, "reload_rd"); chk("reload_val", pm_ps_op, 32'hAAAA5555);

    // Random boots followed by random traffic.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      sq = '{16'($urandom_range(DEPTH, 1))};
      for (int i = 0; i < 2*DEPTH; i++) sq.push_back(16'($urandom));
      send(200, 30, nh);
      chk("rboot_hs", 32'(nh), 32'(1 + 2*int'(sq[0])));
      rand_run(100, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pm_resp.md
# pm_resp

Program-memory responder for the program sequencer's fetch interface. It boots the instruction store from an external 16-bit loader stream and holds the sequencer in stall with NOP opcodes until loading completes. It then serves `ps_pm_add`/`ps_pm_cslt`/`ps_pm_wrb` requests and returns `pm_ps_op` one `clk_fetch` edge later. It sits between the sequencer and the on-chip PM RAM and is the memory-side end of the PS↔PM protocol.

## Interface
- `DEPTH`, 256: number of 32-bit instruction words; power of two, 16..4096.
- `AW`, 8: log2(`DEPTH`); address bits used from `ps_pm_add`.
- `clk_fetch` in 1: fetch clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `ps_pm_cslt` in 1: PM chip select from the sequencer.
- `ps_pm_wrb` in 1: 1 = read, 0 = write.
- `ps_pm_add` in 16: PM word address.
- `ps_pm_wdt` in 32: PM write data; the sequencer ties it to 0.
- `pm_ps_op` out 32: fetched opcode, registered.
- `ldr_vld` in 1: loader halfword valid.
- `ldr_dt` in 16: loader halfword.
- `ldr_rdy` out 1: responder accepts a loader halfword.
- `pm_stallb` out 1: 0 = boot in progress; feeds the sequencer `stallb`.
- `boot_done` out 1: 1 once in RUN.
- `pm_oob` out 1: sticky flag for an access to an address ≥ `DEPTH`.

## Operation
- FSM states are `B_CNT`, `B_HI`, `B_LO` and `RUN`. Reset enters `B_CNT`.
- **B_CNT**
  - `ldr_rdy`=1. On handshake (`ldr_vld`&`ldr_rdy`), latch N = `ldr_dt`.
  - N=0 → go to `RUN`.
  - N>`DEPTH` → clamp N to `DEPTH`; surplus loader data is never accepted.
  - Otherwise clear the load pointer `lp` to 0 and go to `B_HI`.
- **B_HI**: on handshake, latch `hi` ← `ldr_dt` and go to `B_LO`.
- **B_LO**: on handshake, write mem[`lp`] ← {`hi`, `ldr_dt`}.
  - If `lp`=N−1 → go to `RUN`.
  - Else `lp`+1 and go to `B_HI`.
- **Boot states**
  - `pm_ps_op` is forced to 32'h0, which the sequencer decodes as no action.
  - `pm_stallb`=0 and `boot_done`=0.
  - `ps_pm_cslt` is ignored.
- **RUN**
  - `ldr_rdy`=0 and `ldr_vld` is ignored.
  - `pm_stallb`=1 and `boot_done`=1.
- **Read** (RUN, `cslt`=1, `wrb`=1): `pm_ps_op` ← mem[`ps_pm_add[AW-1:0]`].
- **Write** (RUN, `cslt`=1, `wrb`=0): mem[addr] ← `ps_pm_wdt` and `pm_ps_op` ← 32'h0.
- **Idle** (`cslt`=0): `pm_ps_op` holds its value and there is no RAM access.
- **Out of range**: if `ps_pm_add[15:AW]`≠0 with `cslt`=1 in RUN:
  - reads return 32'h0;
  - writes are dropped;
  - `pm_oob` ← 1 and stays set until `rst`.
- The RAM is single-port. The loader owns it in boot states and fetch owns it in RUN, so there is no arbitration.

## Timing
- Reset values: `pm_ps_op`=0, `ldr_rdy`=0, `pm_stallb`=0, `boot_done`=0, `pm_oob`=0. `lp`, N and `hi` are cleared. RAM contents are not reset.
- `ldr_rdy` is registered. It rises on the first posedge after `rst` deasserts.
- A loader halfword transfers on the posedge where `ldr_vld`&`ldr_rdy`=1. `ldr_rdy` remains 1 through `B_CNT`/`B_HI`/`B_LO`, so one halfword per cycle is sustainable.
- Boot length is 1+2N accepted halfwords. `pm_stallb`/`boot_done` rise on the edge that accepts the last halfword.
- Read latency is 1: an address presented before edge k produces `pm_ps_op` valid after edge k.
- Back-to-back reads are supported, one per cycle.
- A read of the same address on the cycle after a write returns the new data.
- The first fetch is accepted on the first edge in RUN, that is, the edge after `boot_done` rises.
- If `rst` is asserted mid-boot, the FSM returns to `B_CNT` and the whole stream must be resent. Partially written RAM words remain and are overwritten by the new load.
- If `rst` is asserted in RUN, the responder reboots; the sequencer is stalled again.

## Structure
- Shared package `pm_pkg` holds:
  - the state enum (`B_CNT`, `B_HI`, `B_LO`, `RUN`);
  - `PM_NOP` = 32'h0;
  - the loader halfword order (high half first).
- Sub-module `pm_ram`: single-port synchronous RAM, `DEPTH`×32, with write enable, address, write data and registered read data.
- The FSM, loader counter, address check and output mux live in `pm_resp`.

## Test plan
- **Reset/boot**: release `rst`; stream N=3 then 1234,5678 / 9ABC,DEF0 / 0000,0001.
  - Expect `pm_stallb`=0 and `pm_ps_op`=0 throughout boot.
  - `boot_done` rises on the 7th handshake.
  - Reads of 0,1,2 return 32'h12345678, 32'h9ABCDEF0, 32'h00000001, each 1 cycle later.
- **Zero count**: N=0 → RUN after 1 handshake; `ldr_rdy`=0 afterwards.
- **Clamp**: with `DEPTH`=16, send N=20 and 32 halfwords.
  - Expect RUN after 33 handshakes.
  - Further `ldr_vld` is ignored.
- **Write/read**: in RUN, write addr 5 with 32'hCAFEF00D (`wrb`=0), then read 5 on the next cycle.
  - Expect `pm_ps_op`=0 after the write edge, then 32'hCAFEF00D.
- **Out of range**: read addr 16'h0100 with `DEPTH`=256 → `pm_ps_op`=0 and `pm_oob`=1, held through subsequent valid reads.
- **Mid-boot reset**: assert `rst` after 4 handshakes.
  - All outputs return to reset values.
  - A fresh N=1 load completes after 3 handshakes.
